// File: rtl/read_rob.sv
// In-order read reorder buffer: allocates TIDs in AR order, accepts out-of-order
// {tid, data} completions and drains them to the AXI R channel in allocation order.
module read_rob #(
  parameter int ID_WIDTH     = 8,
  parameter int DATA_WIDTH   = 512,
  parameter int TID_WIDTH    = 5,
  parameter int AFULL_MARGIN = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          alloc_valid_i,
  input  logic [ID_WIDTH-1:0]           alloc_id_i,
  output logic                          alloc_ready_o,
  output logic [TID_WIDTH-1:0]          alloc_tid_o,
  output logic                          alloc_afull_o,
  input  logic                          rob_wren_i,
  input  logic [TID_WIDTH+DATA_WIDTH-1:0] rob_data_i,
  output logic                          rob_afull_o,
  output logic [ID_WIDTH-1:0]           rid_o,
  output logic [DATA_WIDTH-1:0]         rdata_o,
  output logic [1:0]                    rresp_o,
  output logic                          rlast_o,
  output logic                          rvalid_o,
  input  logic                          rready_i,
  output logic                          err_o
);

  localparam int DEPTH = 2 ** TID_WIDTH;
  localparam logic [TID_WIDTH:0]   DEPTH_CNT  = (TID_WIDTH + 1)'(DEPTH);
  localparam logic [TID_WIDTH:0]   MARGIN_CNT = (TID_WIDTH + 1)'(AFULL_MARGIN);
  localparam logic [TID_WIDTH:0]   CNT_ONE    = (TID_WIDTH + 1)'(1);
  localparam logic [TID_WIDTH-1:0] PTR_ONE    = TID_WIDTH'(1);

  logic [TID_WIDTH-1:0]  head;
  logic [TID_WIDTH-1:0]  tail;
  logic [TID_WIDTH:0]    count;
  logic [TID_WIDTH:0]    free_cnt;
  logic [DEPTH-1:0]      alloc_bits;
  logic [DEPTH-1:0]      done_bits;
  logic [ID_WIDTH-1:0]   id_mem   [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic                  afull_hold;

  logic [TID_WIDTH-1:0]  wr_tid;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ok;
  logic                  do_alloc;
  logic                  loadable;
  logic                  do_drain;

  assign wr_tid  = rob_data_i[TID_WIDTH+DATA_WIDTH-1 -: TID_WIDTH];
  assign wr_data = rob_data_i[DATA_WIDTH-1:0];

  // A completion is only legal for an allocated entry that has not completed yet.
  assign wr_ok    = rob_wren_i & alloc_bits[wr_tid] & ~done_bits[wr_tid];
  assign do_alloc = alloc_valid_i & alloc_ready_o;
  assign loadable = ~rvalid_o | rready_i;
  assign do_drain = loadable & done_bits[head];

  assign free_cnt      = DEPTH_CNT - count;
  assign alloc_ready_o = (count < DEPTH_CNT);
  assign alloc_tid_o   = tail;
  assign alloc_afull_o = (free_cnt <= MARGIN_CNT);
  assign rob_afull_o   = rst | afull_hold;
  assign rresp_o       = 2'b00;
  assign rlast_o       = 1'b1;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_alloc) tail <= tail + PTR_ONE;
      if (do_drain) head <= head + PTR_ONE;
      case ({do_alloc, do_drain})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Per-entry state; alloc/free and complete/free never target the same slot in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_bits <= '0;
      done_bits  <= '0;
    end else begin
      if (do_alloc) alloc_bits[tail]  <= 1'b1;
      if (do_drain) alloc_bits[head]  <= 1'b0;
      if (wr_ok)    done_bits[wr_tid] <= 1'b1;
      if (do_drain) done_bits[head]   <= 1'b0;
    end
  end

  // Entry payload storage, not reset: validity is tracked by the alloc/done bits.
  always_ff @(posedge clk) begin
    if (do_alloc) id_mem[tail]       <= alloc_id_i;
    if (wr_ok)    data_mem[wr_tid]   <= wr_data;
  end

  // AXI R output register; holds its payload while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_o <= 1'b0;
      rid_o    <= '0;
      rdata_o  <= '0;
    end else if (do_drain) begin
      rvalid_o <= 1'b1;
      rid_o    <= id_mem[head];
      rdata_o  <= data_mem[head];
    end else if (loadable) begin
      rvalid_o <= 1'b0;
    end
  end

  // Sticky protocol error and post-reset completion-port hold-off.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_o      <= 1'b0;
      afull_hold <= 1'b1;
    end else begin
      afull_hold <= 1'b0;
      if (rob_wren_i & ~wr_ok) err_o <= 1'b1;
    end
  end

endmodule

// File: doc/read_rob.md
Name: read_rob

Overview:
- In-order read reorder buffer between the tag comparator and the slave-side AXI R channel of the DRAM cache controller.
- The front-end allocates one TID per accepted read request, in AR order, and records its ARID.
- The tag comparator (read hits) and the miss-return path deliver {tid, data} completions out of order through a FIFO-style write port.
- The block drains completions to the AXI R channel strictly in allocation order.

Parameters:
- ID_WIDTH, 8, AXI ID width.
- DATA_WIDTH, 512, line/beat data width.
- TID_WIDTH, 5, transaction tag width; DEPTH = 2**TID_WIDTH entries.
- AFULL_MARGIN, 2, alloc_afull_o asserts when free entries <= this value.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- alloc_valid_i  in  1  front-end requests a TID.
- alloc_id_i  in  ID_WIDTH  ARID stored with the entry.
- alloc_ready_o  out  1  an entry is free.
- alloc_tid_o  out  TID_WIDTH  TID granted on an alloc handshake (= tail pointer).
- alloc_afull_o  out  1  almost-full hint.
- rob_wren_i  in  1  completion write strobe.
- rob_data_i  in  TID_WIDTH+DATA_WIDTH  {tid[MSBs], data[DATA_WIDTH-1:0]}.
- rob_afull_o  out  1  completion-port backpressure.
- rid_o  out  ID_WIDTH  AXI RID.
- rdata_o  out  DATA_WIDTH  AXI RDATA.
- rresp_o  out  2  AXI RRESP, always 2'b00.
- rlast_o  out  1  always 1 (single-beat bursts).
- rvalid_o  out  1  AXI RVALID.
- rready_i  in  1  AXI RREADY.
- err_o  out  1  sticky protocol-error flag.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - head, tail, count = 0; all entry alloc/done bits = 0.
  - rvalid_o = 0, rid_o = 0, rdata_o = 0, err_o = 0.
  - rob_afull_o = 1 while rst is high, and for the first cycle after rst deasserts; 0 thereafter.
  - Reset mid-operation drops all entries and any pending R beat without handshake.
- Per-entry storage: alloc bit, done bit, ARID, data.
- Pointers: head and tail are TID_WIDTH bits and wrap naturally modulo DEPTH. count is TID_WIDTH+1 bits, range 0..DEPTH.
- Allocation:
  - alloc_ready_o = (count < DEPTH), combinational from registered count.
  - alloc_tid_o = tail.
  - On alloc_valid_i & alloc_ready_o: set alloc[tail], store ARID, tail++, count++.
  - alloc_afull_o = (DEPTH - count <= AFULL_MARGIN).
- Completion write, on rob_wren_i with tid = rob_data_i[TID_WIDTH+DATA_WIDTH-1:DATA_WIDTH]:
  - If alloc[tid] & !done[tid]: store data, set done[tid] at the clock edge.
  - Otherwise (unallocated TID, or done already set): discard the write and set err_o (sticky until rst).
  - rob_afull_o is 0 in normal operation; an accepted write never stalls. The port is retained for comparator flow control.
- Drain:
  - R output register is loadable when !rvalid_o | rready_i.
  - If loadable and done[head]: load rid_o/rdata_o from entry[head], rvalid_o = 1, clear alloc[head] and done[head], head++, count--.
  - If loadable and !done[head]: rvalid_o = 0 next cycle.
  - While rvalid_o & !rready_i: rid_o/rdata_o are held stable (AXI rule).
- Latency:
  - Completion write in cycle T to the head TID gives rvalid_o = 1 in cycle T+2.
  - Steady state is 1 beat/cycle with rready_i held high.
- Same-cycle events:
  - Alloc and drain in the same cycle: count is unchanged, both pointers advance.
  - Completion to head in the same cycle as a drain attempt: not visible until the next cycle (done is registered).
  - Alloc into the slot being freed in the same cycle is impossible when count == DEPTH. alloc_ready_o uses the pre-drain count, so a full-to-free transition is visible one cycle later.
- Entries freed by drain become allocatable the following cycle.
- No combinational path from rready_i to alloc_ready_o.

Test Plan:
1. Reset, then 3 allocs with IDs 0x11, 0x22, 0x33 → alloc_tid_o = 0, 1, 2. Completions written in order tid 2, 0, 1 with data A/B/C, rready_i = 1 → R beats in order rid 0x11/B, 0x22/C, 0x33/A, each with rlast_o = 1 and rresp_o = 0.
2. Single alloc, completion for tid 0 at cycle T → rvalid_o first high at T+2. With rready_i = 0 for 4 cycles, rid_o/rdata_o hold stable; handshake on rready_i = 1, then rvalid_o drops next cycle.
3. Allocate 32 with no drain → alloc_ready_o = 0 at count 32, alloc_afull_o = 1 from count 30. Complete tid 0 and drain it → alloc_ready_o returns; the next alloc_tid_o = 0 (wrap).
4. Completion to unallocated tid 7, and a second completion to an already-done tid → both ignored, err_o = 1 and stays set; in-order drain unaffected.
5. Steady stream: alloc and completion each cycle, rready_i = 1 → one R beat per cycle, count constant, no bubbles after the initial 2-cycle latency.
6. Assert rst with 5 entries pending and rvalid_o = 1 → next cycle rvalid_o = 0, count = 0, alloc_tid_o = 0, err_o = 0.
